axi_simple_mem_slave: RTL and testbench
=======================================

Name: axi_simple_mem_slave

Overview:
- AXI4 memory endpoint that terminates one crossbar master port (the "out" side of the simple crossbar) with an on-chip word-addressed memory.
- Accepts INCR bursts only, full-width beats only.
- Supports one outstanding write and one outstanding read at a time; both may be in flight together.
- Used as default RAM target in subsystem benches and small SoC tiles.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 64, AXI data width; power of two, >= 8.
- ID_WIDTH, 4, AXI ID width; must equal the crossbar's master-side ID width.
- MEM_WORDS, 1024, memory depth in DATA_WIDTH words.
- BASE_ADDR, 0, byte address mapped to word 0.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- aw_id / aw_addr / aw_len  in  ID_WIDTH / ADDR_WIDTH / 8  write address.
- aw_valid in 1; aw_ready out 1  AW handshake.
- w_data / w_strb / w_last  in  DATA_WIDTH / DATA_WIDTH/8 / 1  write data.
- w_valid in 1; w_ready out 1  W handshake.
- b_id / b_resp  out  ID_WIDTH / 2  write response.
- b_valid out 1; b_ready in 1  B handshake.
- ar_id / ar_addr / ar_len  in  ID_WIDTH / ADDR_WIDTH / 8  read address.
- ar_valid in 1; ar_ready out 1  AR handshake.
- r_id / r_data / r_resp / r_last  out  ID_WIDTH / DATA_WIDTH / 2 / 1  read data.
- r_valid out 1; r_ready in 1  R handshake.

Behaviour:
- Reset: single clock clk_i, synchronous active-high reset rst_i.
  - While rst_i=1 and the cycle after, all outputs are 0 (aw_ready, ar_ready, w_ready, b_valid, r_valid, and all payloads).
  - Both FSMs go to IDLE. Memory contents are NOT reset.
- Word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). Low address bits are ignored (no unaligned support).
  - Index increments by 1 per beat, with no 4 KiB wrap enforcement.
  - A beat is out of range (OOR) if addr < BASE_ADDR or index >= MEM_WORDS.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: aw_ready=1. On handshake, latch id, index, beats=aw_len+1 (1..256) and clear the error flag.
  - W_DATA: w_ready=1 unless the read FSM holds the memory port this cycle (see arbitration; writes win, so w_ready is effectively 1).
    - Each W handshake writes w_data with byte enables w_strb if in range. OOR beats are dropped and set the error flag.
    - The error flag is also set if w_last differs from (beat==beats-1).
    - The burst ends on the counted final beat regardless of w_last.
  - W_RESP: b_valid=1, b_id=latched id, b_resp=SLVERR (2'b10) if the error flag is set, else OKAY (2'b00). Payload is held stable until b_ready.
- Read FSM: R_IDLE -> R_FETCH -> R_DATA -> (R_FETCH | R_IDLE).
  - R_IDLE: ar_ready=1. On handshake, latch id, index and beats.
  - R_FETCH: issue a memory read (1-cycle latency). If the write path uses the port this cycle, stay in R_FETCH.
  - R_DATA: r_valid=1 with registered data.
    - r_resp=SLVERR and r_data=0 for an OOR beat; otherwise r_resp=OKAY.
    - r_last=1 on the final beat. Payload is held stable until r_ready.
    - Handshake on the last beat goes to R_IDLE, otherwise to R_FETCH with index+1.
  - Latency: first r_valid 2 cycles after the AR handshake with no conflict. Throughput is 1 beat per 2 cycles.
- Arbitration: the single memory port serves one access per cycle; a write beat has priority over a read fetch.
  - Read-after-write on the same word in the same burst window: the read sees the write if the write handshake occurred in an earlier cycle than the read's fetch.
- Simultaneous AW and AR handshakes are both accepted.
- No ATOPs, no user signals; burst/size/lock/cache/prot/qos/region are not present on the ports and are treated as INCR, full width.

Decomposition:
- Package axi_simple_mem_pkg: write FSM state enum, read FSM state enum, RESP_OKAY/RESP_SLVERR constants, and a function computing word index plus OOR flag from addr, BASE_ADDR and MEM_WORDS.
- Sub-module axi_simple_mem_array: single-port RAM, MEM_WORDS x DATA_WIDTH, byte write enables, synchronous 1-cycle read, no reset.

Test Plan:
- Single beat: AW id=3 addr=0x10 len=0; W data=0xDEADBEEF_CAFEF00D strb=0xFF last=1 -> B id=3 OKAY. Then AR id=3 addr=0x10 len=0 -> R same data, last=1, OKAY, r_valid exactly 2 cycles after the AR handshake.
- Burst with strobes: write len=3 at 0x100 with data 0x11..,0x22..,0x33..,0x44.., beat 2 strb=0x0F over prior 0 -> read len=3 returns beat 2 = 0x00000000_33333333, others intact, r_last only on beat 3.
- Out of range (MEM_WORDS=1024, 64-bit, so limit 0x2000): write 0x1FF8 len=1 -> B SLVERR, word 1023 written. Read 0x1FF8 len=1 -> beat 0 OKAY with data, beat 1 SLVERR data 0. w_last asserted on beat 0 of a len=1 write -> SLVERR.
- Conflict: 8-beat write and 8-beat read started the same cycle, w_valid held high -> w_ready never drops, write completes in 8 beats, read data correct, no lost beats.
- Backpressure: b_ready and r_ready held 0 for 5 cycles -> b_valid/r_valid and payloads held stable throughout; no new AW/AR accepted while busy.
- Reset mid-burst: assert rst_i during beat 2 of a 4-beat read -> next cycle r_valid=0 and aw/ar_ready=0. After release, ready=1 and a fresh read returns previously written memory contents.

Source files
------------

// File: rtl/axi_simple_mem_pkg.sv
// Shared types and helpers for the AXI4 single-port memory endpoint.
// Holds FSM state enums, response codes and the address-to-word mapping.
package axi_simple_mem_pkg;

    typedef enum logic [1:0] {
        WIdle,
        WData,
        WResp
    } w_state_e;

    typedef enum logic [1:0] {
        RIdle,
        RFetch,
        RData
    } r_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic        oor;
        logic [63:0] index;
    } word_map_t;

    // Addresses below base or at/after the end of the array are out of range.
    function automatic word_map_t map_addr(input logic [63:0] addr,
                                           input logic [63:0] base,
                                           input logic [63:0] words,
                                           input int unsigned lsb);
        word_map_t   m;
        logic [63:0] off;
        off     = addr - base;
        m.index = off >> lsb;
        m.oor   = (addr < base) || (m.index >= words);
        return m;
    endfunction

endpackage

// File: rtl/axi_simple_mem_slave_if.sv
// Reduced AXI4 channel bundle (no burst/size/prot fields) for the memory endpoint.
interface axi_simple_mem_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic                    aw_valid;
    logic                    aw_ready;

    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic                    w_valid;
    logic                    w_ready;

    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;

    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic                    ar_valid;
    logic                    ar_ready;

    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/axi_simple_mem_array.sv
// Single-port RAM with byte write enables and a registered 1-cycle read, no reset.
// The read register only updates on read accesses, so it holds across writes.
module axi_simple_mem_array #(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_W     = 10
) (
    input  logic                    clk_i,
    input  logic                    en_i,
    input  logic                    we_i,
    input  logic [ADDR_W-1:0]       addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] strb_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (strb_i[b]) begin
                        mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                    end
                end
            end else begin
                rdata_o <= mem[addr_i];
            end
        end
    end

endmodule

// File: rtl/axi_simple_mem_slave.sv
// AXI4 INCR-only memory endpoint: one write and one read burst in flight, sharing a
// single RAM port on which write beats take priority over read fetches.
module axi_simple_mem_slave
    import axi_simple_mem_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 64,
    parameter int unsigned           ID_WIDTH   = 4,
    parameter int unsigned           MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input logic                   clk_i,
    input logic                   rst_i,
    axi_simple_mem_slave_if.slave bus
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned LSB   = $clog2(BYTES);
    localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    w_state_e              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [7:0]            w_len_q, w_len_d;
    logic [7:0]            w_beat_q, w_beat_d;
    logic                  w_err_q, w_err_d;

    r_state_e              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [7:0]            r_len_q, r_len_d;
    logic [7:0]            r_beat_q, r_beat_d;
    logic                  r_oor_q, r_oor_d;

    // Keeps the readies low for one extra cycle after reset is released.
    logic                  rst_hold_q;

    word_map_t             w_map, r_map;
    logic                  w_fire, w_last_beat, r_last_beat;
    logic                  mem_en, mem_we;
    logic [IDX_W-1:0]      mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  unused_idx;

    assign w_map = map_addr(64'(w_addr_q), 64'(BASE_ADDR), 64'(MEM_WORDS), LSB);
    assign r_map = map_addr(64'(r_addr_q), 64'(BASE_ADDR), 64'(MEM_WORDS), LSB);
    assign unused_idx = ^{w_map.index[63:IDX_W], r_map.index[63:IDX_W]};

    assign w_last_beat = (w_beat_q == w_len_q);
    assign r_last_beat = (r_beat_q == r_len_q);

    assign bus.aw_ready = (w_state_q == WIdle) && !rst_hold_q;
    assign bus.w_ready  = (w_state_q == WData) && !rst_hold_q;
    assign bus.ar_ready = (r_state_q == RIdle) && !rst_hold_q;
    assign w_fire       = bus.w_valid && bus.w_ready;

    assign bus.b_valid = (w_state_q == WResp);
    assign bus.b_id    = bus.b_valid ? w_id_q : '0;
    assign bus.b_resp  = (bus.b_valid && w_err_q) ? RESP_SLVERR : RESP_OKAY;

    assign bus.r_valid = (r_state_q == RData);
    assign bus.r_id    = bus.r_valid ? r_id_q : '0;
    assign bus.r_data  = (bus.r_valid && !r_oor_q) ? mem_rdata : '0;
    assign bus.r_resp  = (bus.r_valid && r_oor_q) ? RESP_SLVERR : RESP_OKAY;
    assign bus.r_last  = bus.r_valid && r_last_beat;

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_beat_d  = w_beat_q;
        w_err_d   = w_err_q;
        unique case (w_state_q)
            WIdle: begin
                if (bus.aw_valid && bus.aw_ready) begin
                    w_id_d    = bus.aw_id;
                    w_addr_d  = bus.aw_addr;
                    w_len_d   = bus.aw_len;
                    w_beat_d  = '0;
                    w_err_d   = 1'b0;
                    w_state_d = WData;
                end
            end
            WData: begin
                if (w_fire) begin
                    if (w_map.oor || (bus.w_last != w_last_beat)) begin
                        w_err_d = 1'b1;
                    end
                    // The counted beat ends the burst; w_last only affects the response.
                    if (w_last_beat) begin
                        w_state_d = WResp;
                    end else begin
                        w_beat_d = w_beat_q + 8'd1;
                        w_addr_d = w_addr_q + ADDR_WIDTH'(BYTES);
                    end
                end
            end
            WResp: begin
                if (bus.b_ready) begin
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_beat_d  = r_beat_q;
        r_oor_d   = r_oor_q;
        unique case (r_state_q)
            RIdle: begin
                if (bus.ar_valid && bus.ar_ready) begin
                    r_id_d    = bus.ar_id;
                    r_addr_d  = bus.ar_addr;
                    r_len_d   = bus.ar_len;
                    r_beat_d  = '0;
                    r_state_d = RFetch;
                end
            end
            RFetch: begin
                if (!w_fire) begin
                    r_oor_d   = r_map.oor;
                    r_state_d = RData;
                end
            end
            RData: begin
                if (bus.r_ready) begin
                    if (r_last_beat) begin
                        r_state_d = RIdle;
                    end else begin
                        r_beat_d  = r_beat_q + 8'd1;
                        r_addr_d  = r_addr_q + ADDR_WIDTH'(BYTES);
                        r_state_d = RFetch;
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    // Any write handshake owns the port, even a dropped out-of-range beat.
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = w_map.index[IDX_W-1:0];
        if (w_fire) begin
            mem_en = !w_map.oor;
            mem_we = 1'b1;
        end else if ((r_state_q == RFetch) && !r_map.oor) begin
            mem_en   = 1'b1;
            mem_addr = r_map.index[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q  <= WIdle;
            w_id_q     <= '0;
            w_addr_q   <= '0;
            w_len_q    <= '0;
            w_beat_q   <= '0;
            w_err_q    <= 1'b0;
            r_state_q  <= RIdle;
            r_id_q     <= '0;
            r_addr_q   <= '0;
            r_len_q    <= '0;
            r_beat_q   <= '0;
            r_oor_q    <= 1'b0;
            rst_hold_q <= 1'b1;
        end else begin
            w_state_q  <= w_state_d;
            w_id_q     <= w_id_d;
            w_addr_q   <= w_addr_d;
            w_len_q    <= w_len_d;
            w_beat_q   <= w_beat_d;
            w_err_q    <= w_err_d;
            r_state_q  <= r_state_d;
            r_id_q     <= r_id_d;
            r_addr_q   <= r_addr_d;
            r_len_q    <= r_len_d;
            r_beat_q   <= r_beat_d;
            r_oor_q    <= r_oor_d;
            rst_hold_q <= 1'b0;
        end
    end

    axi_simple_mem_array #(
        .MEM_WORDS  (MEM_WORDS),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (IDX_W)
    ) u_mem (
        .clk_i   (clk_i),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (bus.w_data),
        .strb_i  (bus.w_strb),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_axi_simple_mem_slave.sv
// Directed bench for axi_simple_mem_slave: reset, single/burst access, strobes,
// out-of-range handling, write/read port conflict, backpressure and mid-burst reset.
module tb_axi_simple_mem_slave;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] wd [16];
    logic [7:0]  ws [16];
    logic [63:0] exp_d [16];
    logic [1:0]  exp_r [16];

    axi_simple_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4)) bus ();

    axi_simple_mem_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (64),
        .ID_WIDTH   (4),
        .MEM_WORDS  (1024),
        .BASE_ADDR  (32'h0)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len; bus.aw_valid = 1'b1;
        for (int i = 0; i < 50 && !bus.aw_ready; i++) step();
        chk("aw_ready", bus.aw_ready, 1);
        step();
        bus.aw_valid = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len; bus.ar_valid = 1'b1;
        for (int i = 0; i < 50 && !bus.ar_ready; i++) step();
        chk("ar_ready", bus.ar_ready, 1);
        step();
        bus.ar_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr,
                               input logic [7:0] len, input logic [15:0] last_mask,
                               input logic [1:0] resp);
        aw_send(id, addr, len);
        for (int b = 0; b <= int'(len); b++) begin
            bus.w_valid = 1'b1; bus.w_data = wd[b]; bus.w_strb = ws[b];
            bus.w_last = last_mask[b];
            for (int i = 0; i < 50 && !bus.w_ready; i++) step();
            chk("w_ready", bus.w_ready, 1);
            step();
        end
        bus.w_valid = 1'b0; bus.w_last = 1'b0;
        for (int i = 0; i < 50 && !bus.b_valid; i++) step();
        chk("b_valid", bus.b_valid, 1);
        chk("b_id", bus.b_id, id);
        chk("b_resp", bus.b_resp, resp);
        bus.b_ready = 1'b1;
        step();
        bus.b_ready = 1'b0;
    endtask

    task automatic read_beats(input logic [3:0] id, input logic [7:0] len);
        for (int b = 0; b <= int'(len); b++) begin
            for (int i = 0; i < 50 && !bus.r_valid; i++) step();
            chk("r_valid", bus.r_valid, 1);
            chk("r_id", bus.r_id, id);
            chk("r_data", bus.r_data, exp_d[b]);
            chk("r_resp", bus.r_resp, exp_r[b]);
            chk("r_last", bus.r_last, (b == int'(len)) ? 1 : 0);
            bus.r_ready = 1'b1;
            step();
            bus.r_ready = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_valid = 1'b0;
        bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0; bus.w_valid = 1'b0;
        bus.b_ready = 1'b0;
        bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_valid = 1'b0;
        bus.r_ready = 1'b0;

        // Reset: outputs low during reset and for the cycle after release.
        step(); step();
        chk("rst aw_ready", bus.aw_ready, 0);
        chk("rst ar_ready", bus.ar_ready, 0);
        chk("rst w_ready", bus.w_ready, 0);
        chk("rst b_valid", bus.b_valid, 0);
        chk("rst r_valid", bus.r_valid, 0);
        chk("rst r_data", bus.r_data, 0);
        rst = 1'b0;
        chk("post-rst aw_ready", bus.aw_ready, 0);
        chk("post-rst ar_ready", bus.ar_ready, 0);
        step();
        chk("idle aw_ready", bus.aw_ready, 1);
        chk("idle ar_ready", bus.ar_ready, 1);

        // Single beat write then read with latency check.
        wd[0] = 64'hDEADBEEF_CAFEF00D; ws[0] = 8'hFF;
        write_burst(4'd3, 32'h10, 8'd0, 16'h0001, 2'b00);
        ar_send(4'd3, 32'h10, 8'd0);
        chk("lat1 r_valid", bus.r_valid, 0);
        step();
        chk("lat2 r_valid", bus.r_valid, 1);
        exp_d[0] = 64'hDEADBEEF_CAFEF00D; exp_r[0] = 2'b00;
        read_beats(4'd3, 8'd0);
        chk("single r_valid drop", bus.r_valid, 0);

        // Burst with a partial strobe over zeroed words.
        for (int i = 0; i < 4; i++) begin wd[i] = '0; ws[i] = 8'hFF; end
        write_burst(4'd1, 32'h100, 8'd3, 16'h0008, 2'b00);
        wd[0] = 64'h11111111_11111111; wd[1] = 64'h22222222_22222222;
        wd[2] = 64'h33333333_33333333; wd[3] = 64'h44444444_44444444;
        ws[2] = 8'h0F;
        write_burst(4'd1, 32'h100, 8'd3, 16'h0008, 2'b00);
        exp_d[0] = 64'h11111111_11111111; exp_d[1] = 64'h22222222_22222222;
        exp_d[2] = 64'h00000000_33333333; exp_d[3] = 64'h44444444_44444444;
        for (int i = 0; i < 4; i++) exp_r[i] = 2'b00;
        ar_send(4'd1, 32'h100, 8'd3);
        read_beats(4'd1, 8'd3);

        // Out-of-range second beat, then a write with an early w_last.
        wd[0] = 64'hAAAA0000_00000001; wd[1] = 64'hAAAA0000_00000002;
        ws[0] = 8'hFF; ws[1] = 8'hFF;
        write_burst(4'd2, 32'h1FF8, 8'd1, 16'h0002, 2'b10);
        exp_d[0] = 64'hAAAA0000_00000001; exp_r[0] = 2'b00;
        exp_d[1] = 64'h0; exp_r[1] = 2'b10;
        ar_send(4'd2, 32'h1FF8, 8'd1);
        read_beats(4'd2, 8'd1);
        write_burst(4'd7, 32'h200, 8'd1, 16'h0001, 2'b10);

        // Same-cycle 8-beat write and read; writes keep the port every cycle.
        bus.aw_id = 4'd5; bus.aw_addr = 32'h400; bus.aw_len = 8'd7; bus.aw_valid = 1'b1;
        bus.ar_id = 4'd6; bus.ar_addr = 32'h400; bus.ar_len = 8'd7; bus.ar_valid = 1'b1;
        bus.w_valid = 1'b1; bus.w_strb = 8'hFF; bus.w_last = 1'b0;
        bus.w_data = 64'h55000000_00000000;
        chk("dual ready", {bus.aw_ready, bus.ar_ready}, 2'b11);
        step();
        bus.aw_valid = 1'b0; bus.ar_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.w_data = 64'h55000000_00000000 | 64'(i);
            bus.w_last = (i == 7);
            chk("conflict w_ready", bus.w_ready, 1);
            step();
        end
        bus.w_valid = 1'b0; bus.w_last = 1'b0;
        chk("conflict b_valid", bus.b_valid, 1);
        chk("conflict b_id", bus.b_id, 5);
        chk("conflict b_resp", bus.b_resp, 0);
        bus.b_ready = 1'b1;
        step();
        bus.b_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_d[i] = 64'h55000000_00000000 | 64'(i); exp_r[i] = 2'b00;
        end
        read_beats(4'd6, 8'd7);

        // Backpressure on B and R with new requests pending.
        aw_send(4'd9, 32'h800, 8'd0);
        bus.w_valid = 1'b1; bus.w_data = 64'h0BADF00D_12345678; bus.w_strb = 8'hFF;
        bus.w_last = 1'b1;
        for (int i = 0; i < 50 && !bus.w_ready; i++) step();
        step();
        bus.w_valid = 1'b0; bus.w_last = 1'b0;
        ar_send(4'd2, 32'h10, 8'd0);
        for (int i = 0; i < 50 && !bus.r_valid; i++) step();
        bus.aw_id = 4'd1; bus.aw_addr = 32'h0; bus.aw_len = 8'd0; bus.aw_valid = 1'b1;
        bus.ar_id = 4'd1; bus.ar_addr = 32'h0; bus.ar_len = 8'd0; bus.ar_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp b_valid/id/resp", {bus.b_valid, bus.b_id, bus.b_resp}, {1'b1, 4'd9, 2'b00});
            chk("bp r_valid/id/resp/last",
                {bus.r_valid, bus.r_id, bus.r_resp, bus.r_last}, {1'b1, 4'd2, 2'b00, 1'b1});
            chk("bp r_data", bus.r_data, 64'hDEADBEEF_CAFEF00D);
            chk("bp readies", {bus.aw_ready, bus.ar_ready}, 2'b00);
            step();
        end
        bus.aw_valid = 1'b0; bus.ar_valid = 1'b0;
        bus.b_ready = 1'b1; bus.r_ready = 1'b1;
        step();
        bus.b_ready = 1'b0; bus.r_ready = 1'b0;
        chk("bp release", {bus.b_valid, bus.r_valid}, 2'b00);

        // Reset during beat 2 of a 4-beat read.
        ar_send(4'd4, 32'h100, 8'd3);
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 50 && !bus.r_valid; i++) step();
            chk("mid r_valid", bus.r_valid, 1);
            bus.r_ready = 1'b1;
            step();
            bus.r_ready = 1'b0;
        end
        for (int i = 0; i < 50 && !bus.r_valid; i++) step();
        chk("mid beat2 data", bus.r_data, 64'h00000000_33333333);
        rst = 1'b1;
        step();
        chk("mid rst r_valid", bus.r_valid, 0);
        chk("mid rst readies", {bus.aw_ready, bus.ar_ready}, 2'b00);
        chk("mid rst r_data", bus.r_data, 0);
        rst = 1'b0;
        chk("mid hold readies", {bus.aw_ready, bus.ar_ready}, 2'b00);
        step();
        chk("mid ready again", {bus.aw_ready, bus.ar_ready}, 2'b11);
        exp_d[0] = 64'h11111111_11111111; exp_d[1] = 64'h22222222_22222222;
        exp_d[2] = 64'h00000000_33333333; exp_d[3] = 64'h44444444_44444444;
        for (int i = 0; i < 4; i++) exp_r[i] = 2'b00;
        ar_send(4'd4, 32'h100, 8'd3);
        read_beats(4'd4, 8'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
